alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequential command front-end for the 4-bit combinational ALU. It accepts register-addressed operation commands over a valid/ready interface and holds a 4-entry × 4-bit register file. Each command drives the ALU's operand and control inputs for one cycle, captures the result and flags, writes back, and returns a response over a second valid/ready interface. The ALU is instantiated beside this block at the same level; this block is the initiator of the ALU port set.

## Interface
- DW, 4, data/register width (fixed; ALU is 4-bit)
- NREG, 4, register-file entries (address width 2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_load  in  1  1 = load cmd_imm into rd, no ALU op
- cmd_op  in  4  ALU control code
- cmd_ra, cmd_rb, cmd_rd  in  2 each  source A, source B, destination
- cmd_imm  in  4  immediate for load
- alu_a, alu_b  out  4 each  ALU operands
- alu_ctrl  out  4  ALU control
- alu_result  in  4  ALU result
- alu_flag  in  6  ALU flags {neg, zero, carry, overflow, equal, lessThan}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  4  result written, or 0 on error
- rsp_flag  out  6  captured ALU flags; 0 for load or error
- rsp_err  out  1  command rejected: divide-by-zero or undefined op

## Operation
- FSM states: IDLE, EXEC, RESP
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register the command and the register-file reads of ra/rb. Go to EXEC.
- EXEC: alu_a/alu_b/alu_ctrl come from registers and are stable for the whole cycle. At the end of the cycle, capture alu_result/alu_flag, perform writeback, load the response registers, and go to RESP.
- RESP: rsp_valid=1 and response fields are held stable. On rsp_ready, go to IDLE.
- Ops 0000–1011 are valid. Ops 1100–1111 are errors: rsp_err=1, no writeback.
- Divide by zero (op 0011 with operand B = 0) is an error: rsp_err=1, no writeback, rsp_data=0, rsp_flag=0.
- Load: rd←cmd_imm, rsp_data=cmd_imm, rsp_flag=0, rsp_err=0. alu_ctrl is driven as 0 but ignored.
- ra, rb and rd may alias. The read happens at accept, before writeback.
- Register file resets to all zeros. Only the sequencer writes it.

## Timing
- Command accepted at edge N.
- alu_* change after edge N and remain valid through cycle N+1.
- Writeback and rsp_valid both occur at edge N+2.
- Minimum command spacing is 3 cycles (rsp_ready tied high). There is no overlap: cmd_ready=0 in EXEC and RESP.
- A command issued immediately after another sees the previous writeback, with no hazard.
- Reset values: cmd_ready=0 while rst_n is low and 1 after release; alu_a=alu_b=alu_ctrl=0; rsp_valid=0; rsp_data=0; rsp_flag=0; rsp_err=0; state=IDLE.
- Reset asserted mid-EXEC or mid-RESP aborts immediately. No writeback occurs and the response is lost.
- Backpressure: RESP persists indefinitely while rsp_ready=0, with outputs unchanged.

## Structure
- alu_seq_pkg holds:
  - the state enum
  - opcode localparams: ADD=0000, SUB=0001, MUL=0010, DIV=0011, SHL=0100, SHR=0101, ASR=0110, ROR=0111, AND=1000, OR=1001, XOR=1010, NOT=1011
  - flag bit indices: NEG=5, ZERO=4, CARRY=3, OVF=2, EQ=1, LT=0
  - DW
- Sub-module alu_seq_regfile: NREG×DW register file with 2 async read ports and 1 write port, async active-low reset.
- The bench instantiates alu_sequencer with the ALU attached.

## Test plan
- Load r0=3 and r1=5, then ADD rd=r2 ra=r0 rb=r1 → rsp_data=8, rsp_flag=6'b100101, rsp_valid exactly 2 cycles after accept, r2=8.
- Load r0=2 and r1=3, then SUB → rsp_data=4'hF, rsp_flag=6'b100001.
- Load r0=7 and r1=1, then ADD → rsp_data=8, rsp_flag=6'b100100 (overflow set).
- DIV with rb=0 → rsp_err=1, rsp_data=0, rsp_flag=0, rd unchanged. Op 1101 → rsp_err=1, rd unchanged.
- Hold rsp_ready=0 for 5 cycles with cmd_valid held high → cmd_ready stays 0, response is stable, and the next command is accepted only after the handshake.
- Assert rst_n low during EXEC → all outputs return to reset values, rd is not written, and cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcodes, flag bit positions, FSM states and the registered command payload.
package alu_seq_pkg;

  localparam int unsigned DW   = 4;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned FW   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] OP_ADD = 4'b0000;
  localparam logic [CW-1:0] OP_SUB = 4'b0001;
  localparam logic [CW-1:0] OP_MUL = 4'b0010;
  localparam logic [CW-1:0] OP_DIV = 4'b0011;
  localparam logic [CW-1:0] OP_SHL = 4'b0100;
  localparam logic [CW-1:0] OP_SHR = 4'b0101;
  localparam logic [CW-1:0] OP_ASR = 4'b0110;
  localparam logic [CW-1:0] OP_ROR = 4'b0111;
  localparam logic [CW-1:0] OP_AND = 4'b1000;
  localparam logic [CW-1:0] OP_OR  = 4'b1001;
  localparam logic [CW-1:0] OP_XOR = 4'b1010;
  localparam logic [CW-1:0] OP_NOT = 4'b1011;

  localparam int unsigned FLAG_NEG   = 5;
  localparam int unsigned FLAG_ZERO  = 4;
  localparam int unsigned FLAG_CARRY = 3;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_EQ    = 1;
  localparam int unsigned FLAG_LT    = 0;

  // Command fields still needed after the operands have been read
  typedef struct packed {
    logic          load;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
  } exec_t;

  function automatic logic op_undefined(input logic [CW-1:0] op);
    return op > OP_NOT;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two asynchronous read ports, one write port.
// Contents clear to zero on reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [NREG-1:0][DW-1:0] regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command front-end for the 4-bit ALU: accept, drive operands for one cycle,
// write back, then hold the response until it is consumed.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [CW-1:0] cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic [FW-1:0] alu_flag,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [FW-1:0] rsp_flag,
  output logic          rsp_err
);

  state_t        state_q, state_d;
  exec_t         exec_q;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          accept, exec_done, op_err, wb_en;
  logic [DW-1:0] wb_data;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (cmd_ra),
    .raddr_b (cmd_rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (wb_en),
    .waddr   (exec_q.rd),
    .wdata   (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && cmd_ready) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand B is the registered alu_b, so the divide-by-zero test sees the value the ALU sees
  always_comb begin
    accept    = 1'b0;
    exec_done = 1'b0;
    op_err    = 1'b0;
    wb_en     = 1'b0;
    wb_data   = alu_result;
    accept    = (state_q == IDLE) && cmd_valid && cmd_ready;
    exec_done = (state_q == EXEC);
    op_err    = !exec_q.load &&
                (op_undefined(alu_ctrl) || ((alu_ctrl == OP_DIV) && (alu_b == '0)));
    wb_en     = exec_done && !op_err;
    if (exec_q.load) wb_data = exec_q.imm;
  end

  // Handshake outputs track the next state so they are registered yet cycle-exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      exec_q    <= '0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      if (accept) begin
        alu_a    <= rdata_a;
        alu_b    <= rdata_b;
        alu_ctrl <= cmd_load ? CW'(0) : cmd_op;
        exec_q   <= '{load: cmd_load, rd: cmd_rd, imm: cmd_imm};
      end
      if (exec_done) begin
        rsp_data <= op_err ? DW'(0) : wb_data;
        rsp_flag <= (op_err || exec_q.load) ? FW'(0) : alu_flag;
        rsp_err  <= op_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_load;
  logic [3:0]    cmd_op;
  logic [1:0]    cmd_ra, cmd_rb, cmd_rd;
  logic [3:0]    cmd_imm;
  logic [3:0]    alu_a, alu_b, alu_ctrl, alu_result;
  logic [5:0]    alu_flag;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [3:0]    rsp_data;
  logic [5:0]    rsp_flag;

  int checks   = 0;
  int failures = 0;
  logic [3:0] last_a, last_b, last_ctrl;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err)
  );

  // Reference ALU; undefined ops and divide-by-zero give non-zero garbage
  logic [3:0] res;
  logic [4:0] s5;
  logic [7:0] rot;
  logic       cy, ov;
  always_comb begin
    res = 4'hA; s5 = '0; rot = '0; cy = 1'b0; ov = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        s5 = {1'b0, alu_a} + {1'b0, alu_b};
        res = s5[3:0]; cy = s5[4];
        ov = (alu_a[3] == alu_b[3]) && (res[3] != alu_a[3]);
      end
      OP_SUB: begin
        s5 = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        res = s5[3:0]; cy = s5[4];
        ov = (alu_a[3] != alu_b[3]) && (res[3] != alu_a[3]);
      end
      OP_MUL: res = 4'(alu_a * alu_b);
      OP_DIV: res = (alu_b != 4'd0) ? alu_a / alu_b : 4'hF;
      OP_SHL: res = alu_a << alu_b;
      OP_SHR: res = alu_a >> alu_b;
      OP_ASR: res = 4'($signed(alu_a) >>> alu_b);
      OP_ROR: begin rot = {alu_a, alu_a} >> alu_b[1:0]; res = rot[3:0]; end
      OP_AND: res = alu_a & alu_b;
      OP_OR:  res = alu_a | alu_b;
      OP_XOR: res = alu_a ^ alu_b;
      OP_NOT: res = ~alu_a;
      default: res = 4'hA;
    endcase
    alu_result = res;
    alu_flag = '0;
    alu_flag[FLAG_NEG]   = res[3];
    alu_flag[FLAG_ZERO]  = (res == 4'd0);
    alu_flag[FLAG_CARRY] = cy;
    alu_flag[FLAG_OVF]   = ov;
    alu_flag[FLAG_EQ]    = (alu_a == alu_b);
    alu_flag[FLAG_LT]    = (alu_a < alu_b);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Issue one command with rsp_ready high; returns at the negedge after the response handshake
  task automatic run_cmd(input logic load, input logic [3:0] op, input logic [1:0] ra, rb, rd,
                         input logic [3:0] imm, output logic [3:0] data, output logic [5:0] flag,
                         output logic err, output int waits);
    waits = 0;
    cmd_load = load; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waits < 20) begin @(negedge clk); waits++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL accept_timeout cmd_ready=%b expected=1", cmd_ready);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    last_a = alu_a; last_b = alu_b; last_ctrl = alu_ctrl;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL exec_phase rsp_valid=%b cmd_ready=%b expected=0/0", rsp_valid, cmd_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL rsp_latency rsp_valid=%b expected=1", rsp_valid);
    end
    data = rsp_data; flag = rsp_flag; err = rsp_err;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic load_reg(input logic [1:0] rd, input logic [3:0] imm);
    logic [3:0] d; logic [5:0] f; logic e; int w;
    run_cmd(1'b1, 4'd0, 2'd0, 2'd0, rd, imm, d, f, e, w);
    checks++;
    if (d !== imm || f !== 6'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL load_rsp r%0d data=%h flag=%b err=%b expected=%h/000000/0", rd, d, f, e, imm);
    end
  endtask

  // OR a register with itself: writes back unchanged and reports its value
  task automatic read_reg(input logic [1:0] r, output logic [3:0] v);
    logic [5:0] f; logic e; int w;
    run_cmd(1'b0, OP_OR, r, r, r, 4'd0, v, f, e, w);
  endtask

  task automatic test_reset();
    logic [3:0] v;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; cmd_load = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_imm = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_cmd_ready_low cmd_ready=%b expected=0", cmd_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready_release cmd_ready=%b expected=1", cmd_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 12'd0) begin
      failures++; $display("FAIL reset_alu a=%h b=%h ctrl=%h expected=0", alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_flag, rsp_err} !== 12'd0) begin
      failures++;
      $display("FAIL reset_rsp valid=%b data=%h flag=%b err=%b expected=0", rsp_valid, rsp_data, rsp_flag, rsp_err);
    end
    read_reg(2'd3, v);
    checks++;
    if (v !== 4'd0) begin failures++; $display("FAIL reset_regfile r3=%h expected=0", v); end
  endtask

  task automatic test_add();
    logic [3:0] d, v; logic [5:0] f; logic e; int w;
    load_reg(2'd0, 4'd3);
    load_reg(2'd1, 4'd5);
    run_cmd(1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, d, f, e, w);
    checks++;
    if (last_a !== 4'd3 || last_b !== 4'd5 || last_ctrl !== OP_ADD) begin
      failures++; $display("FAIL add_operands a=%h b=%h ctrl=%h expected=3/5/0", last_a, last_b, last_ctrl);
    end
    checks++;
    if (d !== 4'd8 || f !== 6'b100101 || e !== 1'b0) begin
      failures++; $display("FAIL add_rsp data=%h flag=%b err=%b expected=8/100101/0", d, f, e);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 4'd8) begin failures++; $display("FAIL add_writeback r2=%h expected=8", v); end
  endtask

  task automatic test_sub();
    logic [3:0] d, v; logic [5:0] f; logic e; int w;
    load_reg(2'd0, 4'd2);
    load_reg(2'd1, 4'd3);
    run_cmd(1'b0, OP_SUB, 2'd0, 2'd1, 2'd3, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'hF || f !== 6'b100001 || e !== 1'b0) begin
      failures++; $display("FAIL sub_rsp data=%h flag=%b err=%b expected=f/100001/0", d, f, e);
    end
    read_reg(2'd3, v);
    checks++;
    if (v !== 4'hF) begin failures++; $display("FAIL sub_writeback r3=%h expected=f", v); end
  endtask

  task automatic test_overflow();
    logic [3:0] d; logic [5:0] f; logic e; int w;
    load_reg(2'd0, 4'd7);
    load_reg(2'd1, 4'd1);
    run_cmd(1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'd8 || f !== 6'b100100 || e !== 1'b0) begin
      failures++; $display("FAIL ovf_rsp data=%h flag=%b err=%b expected=8/100100/0", d, f, e);
    end
  endtask

  // r0=7 r1=1: aliased ADD, then an immediate XOR that must see the new r1
  task automatic test_back_to_back();
    logic [3:0] d; logic [5:0] f; logic e; int w;
    run_cmd(1'b0, OP_ADD, 2'd1, 2'd1, 2'd1, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'd2) begin failures++; $display("FAIL alias_add data=%h expected=2", d); end
    run_cmd(1'b0, OP_XOR, 2'd1, 2'd0, 2'd0, 4'd0, d, f, e, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL b2b_spacing waits=%0d expected=0", w); end
    checks++;
    if (d !== 4'd5 || e !== 1'b0) begin
      failures++; $display("FAIL b2b_xor data=%h err=%b expected=5/0", d, e);
    end
    read_reg(2'd0, d);
    checks++;
    if (d !== 4'd5) begin failures++; $display("FAIL b2b_writeback r0=%h expected=5", d); end
  endtask

  // r0=5 r1=2 r2=8
  task automatic test_errors();
    logic [3:0] d, v; logic [5:0] f; logic e; int w;
    load_reg(2'd3, 4'd0);
    run_cmd(1'b0, OP_DIV, 2'd0, 2'd3, 2'd2, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'd0 || f !== 6'd0 || e !== 1'b1) begin
      failures++; $display("FAIL div0_rsp data=%h flag=%b err=%b expected=0/000000/1", d, f, e);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 4'd8) begin failures++; $display("FAIL div0_no_wb r2=%h expected=8", v); end
    run_cmd(1'b0, 4'b1101, 2'd0, 2'd1, 2'd2, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'd0 || f !== 6'd0 || e !== 1'b1) begin
      failures++; $display("FAIL badop_rsp data=%h flag=%b err=%b expected=0/000000/1", d, f, e);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 4'd8) begin failures++; $display("FAIL badop_no_wb r2=%h expected=8", v); end
    run_cmd(1'b0, OP_DIV, 2'd0, 2'd1, 2'd2, 4'd0, d, f, e, w);
    checks++;
    if (d !== 4'd2 || e !== 1'b0) begin
      failures++; $display("FAIL div_ok data=%h err=%b expected=2/0", d, e);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] v;
    rsp_ready = 1'b0;
    cmd_load = 1'b1; cmd_rd = 2'd3; cmd_imm = 4'd9; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_imm = 4'd6;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 4'd9 ||
          rsp_flag !== 6'd0 || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d ready=%b valid=%b data=%h flag=%b err=%b expected=0/1/9/000000/0",
                 i, cmd_ready, rsp_valid, rsp_data, rsp_flag, rsp_err);
      end
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release valid=%b ready=%b expected=0/1", rsp_valid, cmd_ready);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 4'd6) begin
      failures++; $display("FAIL bp_next_cmd valid=%b data=%h expected=1/6", rsp_valid, rsp_data);
    end
    @(posedge clk); @(negedge clk);
    read_reg(2'd3, v);
    checks++;
    if (v !== 4'd6) begin failures++; $display("FAIL bp_writeback r3=%h expected=6", v); end
  endtask

  task automatic test_reset_mid_exec();
    logic [3:0] v;
    load_reg(2'd2, 4'd4);
    cmd_load = 1'b0; cmd_op = OP_ADD; cmd_ra = 2'd2; cmd_rb = 2'd2; cmd_rd = 2'd2;
    cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 4'd4 || alu_b !== 4'd4) begin
      failures++; $display("FAIL mid_exec_operands a=%h b=%h expected=4/4", alu_a, alu_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_ctrl, rsp_data, rsp_flag, rsp_err} !== 25'd0) begin
      failures++;
      $display("FAIL mid_exec_reset ready=%b valid=%b a=%h b=%h ctrl=%h data=%h flag=%b err=%b expected=all0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_ctrl, rsp_data, rsp_flag, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_exec_release ready=%b valid=%b expected=1/0", cmd_ready, rsp_valid);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 4'd0) begin failures++; $display("FAIL mid_exec_no_wb r2=%h expected=0", v); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
